// File: rtl/ebi_bridge.sv
// Asynchronous EBI slave to synchronous register-bank bridge.
// Strobes, address and data share one synchronizer pipe so they stay cycle-aligned.
module ebi_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int RD_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ebi_cs,
  input  logic        ebi_wr,
  input  logic        ebi_rd,
  input  logic [20:0] ebi_addr,
  input  logic [15:0] ebi_data_in,
  output logic [15:0] ebi_data_out,
  output logic        ebi_data_oe,
  output logic [20:0] reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  input  logic        reg_rvalid,
  output logic        busy,
  output logic [1:0]  err
);
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  typedef struct packed {
    logic        cs;
    logic        wr;
    logic        rd;
    logic [20:0] addr;
    logic [15:0] data;
  } ebi_smp_t;

  typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WAIT, HOLD} state_t;

  ebi_smp_t                      raw, s;
  ebi_smp_t [SYNC_STAGES-1:0]    sync_q;
  logic     [SYNC_STAGES-1:0]    vld_pipe;
  state_t                        state, state_nxt;
  logic                          wr_lvl, rd_lvl, wr_q, rd_q, wr_arm, rd_arm;
  logic                          wr_start, rd_start;
  logic                          accept_wr, accept_rd, rd_ok, rd_to;
  logic                          is_rd;
  logic     [CNT_W-1:0]          cnt;
  logic     [20:0]               addr_q;
  logic     [15:0]               wdata_q, dout_q;
  logic     [1:0]                err_q;

  assign raw = {ebi_cs, ebi_wr, ebi_rd, ebi_addr, ebi_data_in};
  assign s   = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      vld_pipe <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
      vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign wr_lvl = s.cs & s.wr;
  assign rd_lvl = s.cs & s.rd;
  // Arming needs a genuine low sample, so a strobe held across reset is not an edge.
  assign wr_start = wr_arm & wr_lvl & ~wr_q;
  assign rd_start = rd_arm & rd_lvl & ~rd_q;

  always_comb begin
    state_nxt = state;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    rd_ok     = 1'b0;
    rd_to     = 1'b0;
    case (state)
      IDLE:
        if (wr_start) begin
          accept_wr = 1'b1;
          state_nxt = WRITE;
        end else if (rd_start) begin
          accept_rd = 1'b1;
          state_nxt = READ_REQ;
        end
      WRITE:    state_nxt = HOLD;
      READ_REQ: state_nxt = READ_WAIT;
      READ_WAIT:
        if (reg_rvalid) begin
          rd_ok     = 1'b1;
          state_nxt = HOLD;
        end else if (cnt == CNT_W'(RD_TIMEOUT - 1)) begin
          rd_to     = 1'b1;
          state_nxt = HOLD;
        end
      HOLD:     if (!s.cs) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_arm  <= 1'b0;
      rd_arm  <= 1'b0;
      is_rd   <= 1'b0;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      err_q   <= '0;
    end else begin
      state  <= state_nxt;
      wr_q   <= wr_lvl;
      rd_q   <= rd_lvl;
      wr_arm <= wr_arm | (vld_pipe[SYNC_STAGES-1] & ~wr_lvl);
      rd_arm <= rd_arm | (vld_pipe[SYNC_STAGES-1] & ~rd_lvl);
      cnt    <= (state == READ_WAIT) ? cnt + 1'b1 : '0;
      if (accept_wr || accept_rd) begin
        addr_q <= s.addr;
        is_rd  <= accept_rd;
      end
      if (accept_wr) wdata_q <= s.data;
      if (rd_ok)      dout_q <= reg_rdata;
      else if (rd_to) dout_q <= 16'hDEAD;
      // A read edge coinciding with an accepted write is dropped and flagged.
      err_q <= err_q | {accept_wr & rd_start, rd_to};
    end
  end

  assign reg_we       = (state == WRITE);
  assign reg_re       = (state == READ_REQ);
  assign busy         = (state != IDLE);
  assign ebi_data_oe  = (state == HOLD) & is_rd & rd_lvl;
  assign ebi_data_out = dout_q;
  assign reg_addr     = addr_q;
  assign reg_wdata    = wdata_q;
  assign err          = err_q;
endmodule

// File: tb/tb_ebi_bridge.sv
// Directed bench for ebi_bridge: write, read, timeout, collision, reset abort, back-to-back.
module tb_ebi_bridge;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ebi_cs = 1'b0, ebi_wr = 1'b0, ebi_rd = 1'b0;
  logic [20:0] ebi_addr = '0;
  logic [15:0] ebi_data_in = '0;
  logic [15:0] ebi_data_out;
  logic        ebi_data_oe;
  logic [20:0] reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we, reg_re;
  logic [15:0] reg_rdata = '0;
  logic        reg_rvalid = 1'b0;
  logic        busy;
  logic [1:0]  err;

  int total = 0;
  int bad   = 0;
  int re_cnt;

  ebi_bridge #(.SYNC_STAGES(2), .RD_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .ebi_cs(ebi_cs), .ebi_wr(ebi_wr), .ebi_rd(ebi_rd),
    .ebi_addr(ebi_addr), .ebi_data_in(ebi_data_in),
    .ebi_data_out(ebi_data_out), .ebi_data_oe(ebi_data_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #2;
    chk("rst_we", 32'(reg_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_dout", 32'(ebi_data_out), 0);
    step(); step();
    reset = 1'b1;
    repeat (5) step();

    // stray rvalid while idle is ignored
    reg_rvalid = 1'b1; reg_rdata = 16'hBEEF;
    step(); step();
    chk("stray_dout", 32'(ebi_data_out), 0);
    chk("stray_busy", 32'(busy), 0);
    reg_rvalid = 1'b0; reg_rdata = '0;

    // write addr 1 data 000F, strobe high 2 cycles
    ebi_cs = 1; ebi_wr = 1; ebi_addr = 21'd1; ebi_data_in = 16'h000F;
    step(); step();
    ebi_cs = 0; ebi_wr = 0;
    chk("wr_pre_we", 32'(reg_we), 0);
    step();
    chk("wr_we", 32'(reg_we), 1);
    chk("wr_addr", 32'(reg_addr), 1);
    chk("wr_data", 32'(reg_wdata), 32'h000F);
    chk("wr_re", 32'(reg_re), 0);
    step();
    chk("wr_we_off", 32'(reg_we), 0);
    chk("wr_hold_busy", 32'(busy), 1);
    step();
    chk("wr_idle_busy", 32'(busy), 0);

    // read addr 1, rvalid 2 cycles after reg_re
    ebi_cs = 1; ebi_rd = 1; ebi_addr = 21'd1;
    step(); step(); step();
    chk("rd_re", 32'(reg_re), 1);
    chk("rd_addr", 32'(reg_addr), 1);
    chk("rd_we", 32'(reg_we), 0);
    step(); step();
    chk("rd_wait_oe", 32'(ebi_data_oe), 0);
    reg_rvalid = 1; reg_rdata = 16'h000F;
    step();
    reg_rvalid = 0; reg_rdata = '0;
    chk("rd_dout", 32'(ebi_data_out), 32'h000F);
    chk("rd_oe", 32'(ebi_data_oe), 1);
    chk("rd_err", 32'(err), 0);
    step(); step();
    chk("rd_oe_held", 32'(ebi_data_oe), 1);
    ebi_cs = 0; ebi_rd = 0;
    step(); step(); step();
    chk("rd_oe_off", 32'(ebi_data_oe), 0);
    chk("rd_idle_busy", 32'(busy), 0);

    // read timeout
    ebi_cs = 1; ebi_rd = 1; ebi_addr = 21'd2;
    repeat (18) step();
    chk("to_pre_err", 32'(err), 0);
    chk("to_pre_busy", 32'(busy), 1);
    step();
    chk("to_dout", 32'(ebi_data_out), 32'hDEAD);
    chk("to_err", 32'(err), 1);
    chk("to_oe", 32'(ebi_data_oe), 1);
    ebi_cs = 0; ebi_rd = 0;
    step(); step(); step();
    chk("to_idle", 32'(busy), 0);

    // good read afterwards, err[0] stays sticky
    ebi_cs = 1; ebi_rd = 1; ebi_addr = 21'd3;
    step(); step(); step();
    chk("rd2_re", 32'(reg_re), 1);
    reg_rvalid = 1; reg_rdata = 16'h5A5A;
    step(); step();
    reg_rvalid = 0; reg_rdata = '0;
    chk("rd2_dout", 32'(ebi_data_out), 32'h5A5A);
    chk("rd2_err", 32'(err), 1);
    ebi_cs = 0; ebi_rd = 0;
    step(); step(); step();

    // collision: write wins, err[1] set
    ebi_cs = 1; ebi_wr = 1; ebi_rd = 1; ebi_addr = 21'd5; ebi_data_in = 16'h1234;
    step(); step(); step();
    chk("col_we", 32'(reg_we), 1);
    chk("col_re", 32'(reg_re), 0);
    chk("col_addr", 32'(reg_addr), 5);
    chk("col_data", 32'(reg_wdata), 32'h1234);
    chk("col_err", 32'(err), 3);
    step();
    chk("col_re_h1", 32'(reg_re), 0);
    chk("col_oe", 32'(ebi_data_oe), 0);
    step();
    chk("col_re_h2", 32'(reg_re), 0);
    ebi_cs = 0; ebi_wr = 0; ebi_rd = 0;
    step(); step(); step();
    chk("col_idle", 32'(busy), 0);

    // reset during READ_WAIT
    ebi_cs = 1; ebi_rd = 1; ebi_addr = 21'd7;
    repeat (4) step();
    chk("rw_busy", 32'(busy), 1);
    #1 reset = 0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_re", 32'(reg_re), 0);
    chk("ar_err", 32'(err), 0);
    chk("ar_dout", 32'(ebi_data_out), 0);
    chk("ar_addr", 32'(reg_addr), 0);
    chk("ar_oe", 32'(ebi_data_oe), 0);
    step(); step();
    reset = 1;
    re_cnt = 0;
    repeat (8) begin step(); re_cnt += int'(reg_re); end
    chk("ar_no_re", 32'(re_cnt), 0);
    ebi_cs = 0; ebi_rd = 0;
    step(); step(); step();
    ebi_cs = 1; ebi_rd = 1; ebi_addr = 21'd9;
    step(); step(); step();
    chk("ar_fresh_re", 32'(reg_re), 1);
    chk("ar_fresh_addr", 32'(reg_addr), 9);
    reg_rvalid = 1; reg_rdata = 16'h0001;
    step(); step();
    reg_rvalid = 0;
    ebi_cs = 0; ebi_rd = 0;
    step(); step(); step();
    chk("ar_idle", 32'(busy), 0);

    // back-to-back write then read, 2-cycle cs gap
    ebi_cs = 1; ebi_wr = 1; ebi_addr = 21'd8; ebi_data_in = 16'hABCD;
    step(); step();
    ebi_cs = 0; ebi_wr = 0;
    step();
    chk("b2b_we", 32'(reg_we), 1);
    chk("b2b_wdata", 32'(reg_wdata), 32'hABCD);
    step();
    ebi_cs = 1; ebi_rd = 1; ebi_addr = 21'h10;
    step(); step(); step();
    chk("b2b_re", 32'(reg_re), 1);
    chk("b2b_raddr", 32'(reg_addr), 32'h10);
    reg_rvalid = 1; reg_rdata = 16'h1111;
    step(); step();
    reg_rvalid = 0;
    chk("b2b_dout", 32'(ebi_data_out), 32'h1111);
    chk("b2b_oe", 32'(ebi_data_oe), 1);
    ebi_cs = 0; ebi_rd = 0;
    step(); step(); step();

    // read edge during HOLD (cs still high) is ignored
    ebi_cs = 1; ebi_wr = 1; ebi_addr = 21'h20; ebi_data_in = 16'h0055;
    step(); step(); step();
    chk("ign_we", 32'(reg_we), 1);
    ebi_wr = 0; ebi_rd = 1;
    re_cnt = 0;
    repeat (6) begin step(); re_cnt += int'(reg_re); end
    chk("ign_hold", 32'(busy), 1);
    ebi_cs = 0; ebi_rd = 0;
    repeat (4) begin step(); re_cnt += int'(reg_re); end
    chk("ign_no_re", 32'(re_cnt), 0);
    chk("ign_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
